// File: rtl/sfir_output_stage.sv
// sfir_output_stage: output stage of the even-symmetric systolic FIR chain.
// Re-aligns sample validity with the chain latency. Rounds (half toward +inf),
// shifts and saturates the cascade accumulator, then buffers the result in a
// small first-word-fall-through FIFO on a valid/ready stream. The chain cannot
// stall, so a write into a full FIFO with no concurrent read is dropped and
// flagged on a sticky overflow bit.
//
// Optional feature: define SFIR_OUT_SAT_CNT_EN to build the 16-bit saturating
// counter of saturated samples on sat_count_o; otherwise sat_count_o is tied to 0.
module sfir_output_stage #(
  parameter int unsigned ACC_WIDTH    = 40,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned SHIFT        = 15,
  parameter int unsigned PIPE_LATENCY = 20,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 sat_o,
  output logic                 overflow_o,
  output logic [15:0]          sat_count_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Rounding constant 2^(SHIFT-1) in the widened accumulator format.
  localparam logic signed [ACC_WIDTH:0] RndConst = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);

  // Representable output range, expressed in the shifted-value width.
  localparam logic signed [ACC_WIDTH:0] ShfMax =
      {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ShfMin =
      {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Valid alignment
  // ---------------------------------------------------------------------------
  logic [PIPE_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic                    acc_vld;

  // Shift in_valid_i along the delay line matching the chain latency.
  always_comb begin
    vld_sr_d    = vld_sr_q;
    vld_sr_d[0] = in_valid_i;
    for (int i = 1; i < int'(PIPE_LATENCY); i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  // Delay-line state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
    end
  end

  assign acc_vld = vld_sr_q[PIPE_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Stage 1: round
  // ---------------------------------------------------------------------------
  logic                    s1_vld_q;
  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] rnd_q, rnd_d;

  // Sign-extend by one bit so the rounding add cannot wrap.
  always_comb begin
    acc_ext = {acc_i[ACC_WIDTH-1], acc_i};
    rnd_d   = acc_ext + RndConst;
  end

  // Stage-1 register; data only loads on a qualified accumulator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      rnd_q    <= '0;
    end else begin
      s1_vld_q <= acc_vld;
      if (acc_vld) begin
        rnd_q <= rnd_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift and saturate
  // ---------------------------------------------------------------------------
  logic                      s2_vld_q;
  logic [OUT_WIDTH-1:0]      s2_data_q, s2_data_d;
  logic                      s2_sat_q, s2_sat_d;
  logic signed [ACC_WIDTH:0] shf;

  // Arithmetic shift, then clamp to the signed output range.
  always_comb begin
    shf       = rnd_q >>> SHIFT;
    s2_sat_d  = 1'b0;
    s2_data_d = shf[OUT_WIDTH-1:0];
    if (shf > ShfMax) begin
      s2_data_d = OutMax;
      s2_sat_d  = 1'b1;
    end else if (shf < ShfMin) begin
      s2_data_d = OutMin;
      s2_sat_d  = 1'b1;
    end
  end

  // Stage-2 register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_data_q <= s2_data_d;
        s2_sat_q  <= s2_sat_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] last_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // Push/pop decisions; a full FIFO still accepts when the head leaves this edge.
  always_comb begin
    full     = (cnt_q == CntW'(FIFO_DEPTH));
    empty    = (cnt_q == '0);
    pop      = !empty && m_ready_i;
    push     = s2_vld_q && (!full || m_ready_i);
    drop     = s2_vld_q && full && !m_ready_i;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  // Pointers, occupancy and the last-popped word for the empty-hold behaviour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (pop) begin
        last_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // First-word fall-through head; hold the last delivered word when empty.
  always_comb begin
    m_valid_o = !empty;
    m_data_o  = empty ? last_q : mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  logic sat_q;
  logic ovf_q;

  // sat pulse follows an accepted saturated write; overflow is sticky.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= push && s2_sat_q;
      ovf_q <= ovf_q | drop;
    end
  end

  assign sat_o      = sat_q;
  assign overflow_o = ovf_q;

`ifdef SFIR_OUT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Count with the same event that raises sat_o, sticking at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (push && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Saturated-sample counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count_o = sat_cnt_q;
`else
  assign sat_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_sfir_output_stage.sv
// Self-checking bench for sfir_output_stage: a table of rounding/saturation
// vectors, hand sequences for latency, backpressure, full-with-read and reset,
// and a randomized run against a cycle-level FIFO/arithmetic model.
module tb_sfir_output_stage;

  localparam int unsigned AccW  = 40;
  localparam int unsigned OutW  = 16;
  localparam int unsigned Shift = 15;
  localparam int unsigned Lat   = 20;
  localparam int unsigned Depth = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            in_valid_i;
  logic [AccW-1:0] acc_i;
  logic [OutW-1:0] m_data_o;
  logic            m_valid_o;
  logic            m_ready_i;
  logic            sat_o;
  logic            overflow_o;
  logic [15:0]     sat_count_o;

  always #5 clk = ~clk;

  sfir_output_stage #(
    .ACC_WIDTH   (AccW),
    .OUT_WIDTH   (OutW),
    .SHIFT       (Shift),
    .PIPE_LATENCY(Lat),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .acc_i      (acc_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .sat_o      (sat_o),
    .overflow_o (overflow_o),
    .sat_count_o(sat_count_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;  // number of rising edges so far

  // Model state: per-cycle schedules (index = cycle mod 64) and a FIFO queue.
  longint      nxt_acc;
  bit          acc_v   [64];
  longint      acc_val [64];
  bit          wr_v    [64];
  longint      wr_acc  [64];
  logic [15:0] mq[$];
  logic [15:0] m_last;
  bit          m_ovf;
  bit          m_sat;
  int unsigned m_scnt;

  typedef struct {
    longint      acc;
    logic [15:0] d;
    bit          s;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Reference arithmetic: round half up, arithmetic shift, clamp.
  function automatic void ref_out(input longint a, output logic [15:0] d, output bit s);
    longint r;
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (OutW - 1)) - 1;
    mn = -(longint'(1) <<< (OutW - 1));
    r  = (a + (longint'(1) <<< (Shift - 1))) >>> Shift;
    s  = 1'b1;
    if (r > mx)      d = 16'h7FFF;
    else if (r < mn) d = 16'h8000;
    else begin
      s = 1'b0;
      d = r[15:0];
    end
  endfunction

  // Advance one clock: update the model for this edge, then compare after it.
  task automatic tick();
    int          ne;
    int          sl;
    int          sz;
    logic [15:0] d;
    bit          s;
    ne    = e + 1;
    sl    = ne % 64;
    m_sat = 1'b0;
    if (rst_i) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_scnt = 0;
      for (int i = 0; i < 64; i++) begin
        acc_v[i] = 1'b0;
        wr_v[i]  = 1'b0;
      end
    end else begin
      sz = mq.size();
      if (sz > 0 && m_ready_i) m_last = mq.pop_front();
      if (wr_v[sl]) begin
        ref_out(wr_acc[sl], d, s);
        if (sz < int'(Depth) || m_ready_i) begin
          mq.push_back(d);
          if (s) begin
            m_sat = 1'b1;
            if (m_scnt < 65535) m_scnt++;
          end
        end else begin
          m_ovf = 1'b1;
        end
        wr_v[sl] = 1'b0;
      end
      if (in_valid_i) begin
        acc_v[(e + Lat) % 64]       = 1'b1;
        acc_val[(e + Lat) % 64]     = nxt_acc;
        wr_v[(e + Lat + 3) % 64]    = 1'b1;
        wr_acc[(e + Lat + 3) % 64]  = nxt_acc;
      end
    end
    @(posedge clk);
    e = ne;
    #1;
    chk("m_valid", m_valid_o, mq.size() > 0);
    chk("m_data", m_data_o, (mq.size() > 0) ? mq[0] : m_last);
    chk("sat_o", sat_o, m_sat);
    chk("overflow_o", overflow_o, m_ovf);
`ifdef SFIR_OUT_SAT_CNT_EN
    chk("sat_count", sat_count_o, m_scnt);
`else
    chk("sat_count", sat_count_o, 0);
`endif
    // Accumulator is junk unless the model scheduled a value for this cycle.
    if (acc_v[e % 64]) begin
      acc_i          = acc_val[e % 64][AccW-1:0];
      acc_v[e % 64]  = 1'b0;
    end else begin
      acc_i = AccW'({$urandom(), $urandom()});
    end
  endtask

  task automatic send(input longint a);
    in_valid_i = 1'b1;
    nxt_acc    = a;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  function automatic longint rand_acc();
    logic [AccW-1:0] t;
    longint          k;
    case ($urandom_range(0, 3))
      0: return longint'($signed($urandom()));
      1: begin
        k = longint'(32'h4000_0000) + longint'($urandom_range(0, 65535)) - 32768;
        return $urandom_range(0, 1) ? k : -k;
      end
      2: begin
        t = AccW'({$urandom(), $urandom()});
        return longint'($signed(t));
      end
      default: begin
        k = longint'($urandom_range(0, 65535)) - 32768;
        return k * 32768 + 16383 + longint'($urandom_range(0, 2));
      end
    endcase
  endfunction

  initial begin
    int es;
    int n_sat;
    bit seen;

    vt[0]  = '{acc: 114688,              d: 16'h0004, s: 1'b0};
    vt[1]  = '{acc: -16384,              d: 16'h0000, s: 1'b0};
    vt[2]  = '{acc: -16385,              d: 16'hFFFF, s: 1'b0};
    vt[3]  = '{acc: -49152,              d: 16'hFFFF, s: 1'b0};
    vt[4]  = '{acc: 64'sd34359738368,    d: 16'h7FFF, s: 1'b1};
    vt[5]  = '{acc: -64'sd34359738368,   d: 16'h8000, s: 1'b1};
    vt[6]  = '{acc: 16383,               d: 16'h0000, s: 1'b0};
    vt[7]  = '{acc: 16384,               d: 16'h0001, s: 1'b0};
    vt[8]  = '{acc: 1073725439,          d: 16'h7FFF, s: 1'b0};
    vt[9]  = '{acc: 1073725440,          d: 16'h7FFF, s: 1'b1};
    vt[10] = '{acc: -1073758208,         d: 16'h8000, s: 1'b0};
    vt[11] = '{acc: -1073758209,         d: 16'h8000, s: 1'b1};

    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    m_ready_i  = 1'b1;
    acc_i      = '0;
    nxt_acc    = 0;

    // Reset held for three cycles.
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_cnt", sat_count_o, 0);

    // Latency: in_valid driven just after edge 10 -> valid after edge 33.
    while (e < 10) tick();
    send(114688);
    while (e < 32) tick();
    chk("lat_early", m_valid_o, 0);
    tick();
    chk("lat_valid", m_valid_o, 1);
    chk("lat_data", m_data_o, 4);
    chk("lat_sat", sat_o, 0);
    repeat (3) tick();

    // Table of rounding and saturation vectors.
    n_sat = 0;
    for (int i = 0; i < 12; i++) begin
      send(vt[i].acc);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (m_valid_o) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      chk($sformatf("vec%0d_seen", i), seen, 1);
      chk($sformatf("vec%0d_data", i), m_data_o, vt[i].d);
      chk($sformatf("vec%0d_sat", i), sat_o, vt[i].s);
      if (vt[i].s) n_sat++;
      tick();
    end
`ifdef SFIR_OUT_SAT_CNT_EN
    chk("tbl_sat_count", sat_count_o, n_sat);
`else
    chk("tbl_sat_count", sat_count_o, 0);
`endif

    // Backpressure: six samples into a four-entry FIFO.
    do_reset();
    m_ready_i = 1'b0;
    for (int v = 1; v <= 6; v++) send(longint'(v) <<< Shift);
    repeat (30) tick();
    chk("bp_ovf", overflow_o, 1);
    chk("bp_valid", m_valid_o, 1);
    chk("bp_head", m_data_o, 1);
    m_ready_i = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("bp_rd%0d_valid", v), m_valid_o, 1);
      chk($sformatf("bp_rd%0d_data", v), m_data_o, v);
      tick();
    end
    chk("bp_empty", m_valid_o, 0);

    // Full FIFO with a read on the same edge as the fifth write.
    do_reset();
    m_ready_i = 1'b0;
    es = e;
    for (int v = 10; v <= 14; v++) send(longint'(v) <<< Shift);
    while (e < es + int'(Lat) + 6) tick();
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    tick();
    chk("fr_ovf", overflow_o, 0);
    chk("fr_head", m_data_o, 11);
    m_ready_i = 1'b1;
    for (int v = 11; v <= 14; v++) begin
      chk($sformatf("fr_rd%0d_valid", v), m_valid_o, 1);
      chk($sformatf("fr_rd%0d_data", v), m_data_o, v);
      tick();
    end
    chk("fr_empty", m_valid_o, 0);

    // Reset mid-stream: three buffered words, five samples in flight.
    m_ready_i = 1'b0;
    for (int v = 20; v <= 25; v++) send(longint'(v) <<< Shift);
    repeat (30) tick();
    chk("mr_ovf_pre", overflow_o, 1);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    for (int v = 30; v <= 34; v++) send(longint'(v) <<< Shift);
    repeat (3) tick();
    do_reset();
    chk("mr_valid", m_valid_o, 0);
    chk("mr_ovf", overflow_o, 0);
    chk("mr_data", m_data_o, 0);
    m_ready_i = 1'b1;
    for (int c = 0; c < int'(Lat) + 5; c++) begin
      tick();
      chk("mr_quiet", m_valid_o, 0);
    end
    es = e;
    send(longint'(7) <<< Shift);
    while (e < es + int'(Lat) + 2) tick();
    chk("mr_new_early", m_valid_o, 0);
    tick();
    chk("mr_new_valid", m_valid_o, 1);
    chk("mr_new_data", m_data_o, 7);

    // Randomized traffic with periodic stalls, checked every cycle by the model.
    for (int c = 0; c < 2000; c++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      nxt_acc    = rand_acc();
      m_ready_i  = ((c % 250) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid_i = 1'b0;
    m_ready_i  = 1'b1;
    repeat (40) tick();
    chk("final_empty", m_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfir_output_stage.md
Name: sfir_output_stage

Overview:
Downstream stage of the even-symmetric systolic FIR chain. Consumes the final cascade accumulator (`casc_o` of the last element) and re-aligns sample validity with the chain latency. It rounds and saturates the accumulator to the output width and buffers results in a small FIFO, presented on a valid/ready stream. The systolic chain cannot stall, so backpressure beyond FIFO capacity is flagged as overflow.

Parameters:
- ACC_WIDTH, 40, width of cascade accumulator input (signed).
- OUT_WIDTH, 16, width of output sample (signed).
- SHIFT, 15, right-shift applied after rounding; 1 <= SHIFT < ACC_WIDTH.
- PIPE_LATENCY, 20, cycles from `in_valid_i` to the matching accumulator value on `acc_i`; >= 1.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- in_valid_i  input  1  asserted with each sample entering the FIR chain
- acc_i  input  ACC_WIDTH  cascade accumulator from the last systolic element
- m_data_o  output  OUT_WIDTH  rounded/saturated sample, FIFO head
- m_valid_o  output  1  FIFO non-empty
- m_ready_i  input  1  downstream accept
- sat_o  output  1  one-cycle pulse when a sample written to the FIFO was saturated
- overflow_o  output  1  sticky; a sample was dropped because the FIFO was full
- sat_count_o  output  16  saturating count of saturated samples (see Optional Feature)

Behaviour:
- **Reset.** One clock and one reset: `clk_i`, `rst_i`, synchronous, active-high. Reset clears the valid delay line, both pipeline stages, FIFO pointers and count, `sat_o`, `overflow_o` and `sat_count_o`. Outputs after reset: `m_valid_o`=0, `m_data_o`=0, `sat_o`=0, `overflow_o`=0, `sat_count_o`=0. Reset mid-operation discards all in-flight and buffered samples; there is no partial output.
- **Valid alignment.** `in_valid_i` feeds a PIPE_LATENCY-deep shift register. Its last tap (`acc_vld`) qualifies `acc_i` in that same cycle. `acc_i` is ignored when `acc_vld`=0.
- **Stage 1, registered.** `rnd` = `acc_i` + 2^(SHIFT-1), computed in ACC_WIDTH+1 bits signed (round half toward +inf); valid propagates.
- **Stage 2, registered.** `shf` = `rnd` >>> SHIFT (arithmetic). If `shf` > 2^(OUT_WIDTH-1)-1, output the max positive and set the sat flag. If `shf` < -2^(OUT_WIDTH-1), output the min negative and set the sat flag. Otherwise output `shf` truncated to OUT_WIDTH.
- **FIFO write.** Occurs on the cycle stage-2 valid=1.
  - FIFO not full: write data; `sat_o` pulses on the following cycle if the sat flag was set.
  - FIFO full and `m_ready_i`=0 at the same edge: the sample is dropped, `overflow_o` sets (sticky until reset) and `sat_o` is not pulsed.
  - FIFO full and `m_ready_i`=1 at the same edge: the read and write both succeed, with no overflow.
- **FIFO read.** A word is popped on `m_valid_o` & `m_ready_i`. `m_data_o` shows the head (first-word fall-through). `m_data_o` holds its last value when empty.
- **Stream rules.** `m_valid_o` never deasserts without a handshake while data remains. `m_data_o` is stable while `m_valid_o`=1 and `m_ready_i`=0.
- **Pointers and count.** Read/write pointers wrap modulo FIFO_DEPTH. Count tracks 0..FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.
- **Latency.** With the FIFO empty, a sample whose `in_valid_i` is high at edge k appears with `m_valid_o`=1 in the cycle after edge k+PIPE_LATENCY+3.
- **Throughput.** One sample per cycle sustained when `m_ready_i`=1.

Optional Feature:
- **Macro:** `SFIR_OUT_SAT_CNT_EN`.
- **Defined:** `sat_count_o` increments on each `sat_o` pulse. It saturates at 16'hFFFF (no wrap) and clears only on reset.
- **Undefined:** counter logic is absent and `sat_count_o` is tied to 0. `sat_o` and all other behaviour are unchanged.

Test Plan:
- Reset/latency: `rst_i` held 3 cycles, then `in_valid_i` pulse at edge 10 with `acc_i`=114688 (3·2^15 + 2^14) presented when `acc_vld`=1 -> `m_valid_o` rises after edge 33 (PIPE_LATENCY=20), `m_data_o`=4, `sat_o`=0.
- Rounding, negative values: `acc_i`=-16384 -> 0; `acc_i`=-16385 -> -1; `acc_i`=-49152 -> -1; each with `sat_o`=0.
- Saturation: `acc_i`=2^35 -> 32767, `sat_o` pulse; `acc_i`=-2^35 -> -32768, `sat_o` pulse. With `SFIR_OUT_SAT_CNT_EN`, `sat_count_o`=2; without it, `sat_count_o`=0.
- Backpressure/overflow: `m_ready_i`=0, 6 consecutive valid samples 1..6 -> FIFO holds 1..4, `overflow_o`=1 from the 5th write. Then `m_ready_i`=1 -> 1,2,3,4 read out in order, then `m_valid_o`=0.
- Full with simultaneous read: FIFO full and `m_ready_i`=1 on the same edge as a write -> no overflow, count stays 4, order preserved.
- Reset mid-stream: FIFO holding 3 words and 5 samples in flight, assert `rst_i` 1 cycle -> `m_valid_o`=0 next cycle and stays 0 until new `in_valid_i` + PIPE_LATENCY+3; `overflow_o` cleared.
